gpio_seq_gen: RTL and testbench

GPIO_SEQ_GEN -- requirements
Module: gpio_seq_gen

---
 rtl/gpiotest_pkg.sv | 6 +
 rtl/gpio_edge_det.sv | 12 +
 rtl/gpio_seq_gen.sv | 113 +++++++++++
 tb/tb_gpio_seq_gen.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/gpiotest_pkg.sv
// gpiotest_pkg: shared widths, defaults and state encoding for the GPIO sequencer
package gpiotest_pkg;
  localparam int SEQ_W = 6;
  localparam int NUM_PINS_DEFAULT = 48;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} seq_state_t;
endpackage

// File: rtl/gpio_edge_det.sv
// gpio_edge_det: rising-edge detector with a registered history bit
module gpio_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o
);
  logic d_q;
  // history tracks the input every cycle regardless of sequencer state
  always_ff @(posedge clk_i) d_q <= rst_i ? 1'b0 : d_i;
  assign rise_o = d_i & ~d_q;
endmodule

// File: rtl/gpio_seq_gen.sv
// gpio_seq_gen: GPIO pin index sequencer with run/pause/step control; GPIO_SEQ_PINGPONG_EN selects ping-pong sweep
module gpio_seq_gen
  import gpiotest_pkg::*;
#(
  parameter int NUM_PINS     = NUM_PINS_DEFAULT,
  parameter int DWELL_CYCLES = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic             stop_i,
  input  logic             step_i,
  output logic [SEQ_W-1:0] seq_o,
  output logic             seq_valid_o,
  output logic             step_o,
  output logic             wrap_o
);
  localparam int DW = DWELL_CYCLES > 1 ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [SEQ_W-1:0] LAST = SEQ_W'(NUM_PINS - 1);
  localparam logic [DW-1:0] DLAST = DW'(DWELL_CYCLES - 1);
  generate
    if (NUM_PINS < 2 || NUM_PINS > 64) begin : g_bad_pins
      $error("gpio_seq_gen: NUM_PINS must be 2..64");
    end
    if (DWELL_CYCLES < 1) begin : g_bad_dwell
      $error("gpio_seq_gen: DWELL_CYCLES must be >= 1");
    end
  endgenerate
  seq_state_t state_q, state_d;
  logic [SEQ_W-1:0] seq_q, seq_d, adv_seq;
  logic [DW-1:0] dwell_q, dwell_d;
  logic valid_q, valid_d, step_q, step_d, wrap_q, wrap_d;
  logic adv, adv_wrap, step_edge;
  gpio_edge_det u_edge (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (step_i),
    .rise_o (step_edge)
  );
`ifdef GPIO_SEQ_PINGPONG_EN
  logic dir_q, dir_d, adv_dir;
  // next index for a ping-pong sweep; dir_q=1 means sweeping down, wrap marks the 0 -> 1 reversal
  always_comb begin
    adv_seq = dir_q ? (seq_q == '0 ? SEQ_W'(1) : seq_q - 1'b1) : (seq_q == LAST ? LAST - 1'b1 : seq_q + 1'b1);
    adv_dir = dir_q ? (seq_q != '0) : (seq_q == LAST);
    adv_wrap = dir_q && seq_q == '0;
  end
  assign dir_d = stop_i ? 1'b0 : adv ? adv_dir : dir_q;
  // direction register, up after reset or stop
  always_ff @(posedge clk_i) dir_q <= rst_i ? 1'b0 : dir_d;
`else
  // next index for an up-only sweep, wrapping explicitly at the last pin
  always_comb begin
    adv_seq = seq_q == LAST ? '0 : seq_q + 1'b1;
    adv_wrap = seq_q == LAST;
  end
`endif
  // state register and all registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      seq_q <= '0;
      dwell_q <= '0;
      valid_q <= 1'b0;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q <= seq_d;
      dwell_q <= dwell_d;
      valid_q <= valid_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
    end
  end
  // next state: stop beats run, run beats a step edge
  always_comb state_d = stop_i ? IDLE : run_i ? RUN : (state_q == IDLE && !step_edge) ? IDLE : PAUSE;
  // datapath next values: dwell counting in RUN, single advances on step edges in PAUSE
  always_comb begin
    seq_d = seq_q;
    dwell_d = dwell_q;
    valid_d = valid_q;
    step_d = 1'b0;
    wrap_d = 1'b0;
    adv = 1'b0;
    if (stop_i) begin
      seq_d = '0;
      dwell_d = '0;
      valid_d = 1'b0;
    end else if (state_q == IDLE) begin
      if (run_i || step_edge) begin
        seq_d = '0;
        dwell_d = '0;
        valid_d = 1'b1;
      end
    end else if (state_q == RUN && run_i) begin
      adv = dwell_q == DLAST;
      dwell_d = adv ? '0 : dwell_q + 1'b1;
    end else if (state_q == PAUSE && !run_i && step_edge) begin
      adv = 1'b1;
      dwell_d = '0;
    end
    if (adv) begin
      seq_d = adv_seq;
      step_d = 1'b1;
      wrap_d = adv_wrap;
    end
  end
  assign seq_o = seq_q;
  assign seq_valid_o = valid_q;
  assign step_o = step_q;
  assign wrap_o = wrap_q;
endmodule

// File: tb/tb_gpio_seq_gen.sv
// tb_gpio_seq_gen: directed self-checking bench for gpio_seq_gen
module tb_gpio_seq_gen;
  logic clk = 1'b0;
  logic rst = 1'b1, run = 1'b0, stop = 1'b0, step = 1'b0;
  logic [5:0] seq;
  logic valid, stp, wrap;
  logic rst1 = 1'b1, run1 = 1'b0, stop1 = 1'b0, step1 = 1'b0;
  logic [5:0] seq1;
  logic valid1, stp1, wrap1;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  gpio_seq_gen #(.NUM_PINS(48), .DWELL_CYCLES(4)) dut (
    .clk_i(clk), .rst_i(rst), .run_i(run), .stop_i(stop), .step_i(step),
    .seq_o(seq), .seq_valid_o(valid), .step_o(stp), .wrap_o(wrap)
  );
  gpio_seq_gen #(.NUM_PINS(48), .DWELL_CYCLES(1)) dut1 (
    .clk_i(clk), .rst_i(rst1), .run_i(run1), .stop_i(stop1), .step_i(step1),
    .seq_o(seq1), .seq_valid_o(valid1), .step_o(stp1), .wrap_o(wrap1)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1; run = 1'b1; step = 1'b1; stop = 1'b1;
    tick(); tick();
    n_chk++; if ({seq, valid, stp, wrap} !== 9'b0) begin n_fail++; $display("FAIL reset_state got %h exp 0", {seq, valid, stp, wrap}); end
    step = 1'b0; stop = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    n_chk++; if ({seq, valid, stp, wrap} !== {6'd0, 3'b100}) begin n_fail++; $display("FAIL reset_release_run got %h exp %h", {seq, valid, stp, wrap}, {6'd0, 3'b100}); end
  endtask
  task automatic test_run_sweep();
    for (int k = 1; k <= 47; k++) begin
      repeat (3) begin
        tick();
        n_chk++; if ({seq, stp, wrap} !== {6'(k - 1), 2'b00}) begin n_fail++; $display("FAIL sweep_dwell k=%0d got seq=%0d step=%b wrap=%b", k, seq, stp, wrap); end
      end
      tick();
      n_chk++; if ({seq, stp, wrap} !== {6'(k), 2'b10}) begin n_fail++; $display("FAIL sweep_adv k=%0d got seq=%0d step=%b wrap=%b", k, seq, stp, wrap); end
    end
    repeat (4) tick();
`ifdef GPIO_SEQ_PINGPONG_EN
    n_chk++; if ({seq, stp, wrap} !== {6'd46, 2'b10}) begin n_fail++; $display("FAIL sweep_end got seq=%0d step=%b wrap=%b exp 46 1 0", seq, stp, wrap); end
`else
    n_chk++; if ({seq, stp, wrap} !== {6'd0, 2'b11}) begin n_fail++; $display("FAIL sweep_wrap got seq=%0d step=%b wrap=%b exp 0 1 1", seq, stp, wrap); end
`endif
    tick();
    n_chk++; if ({stp, wrap} !== 2'b00) begin n_fail++; $display("FAIL wrap_one_cycle got step=%b wrap=%b exp 0 0", stp, wrap); end
  endtask
  task automatic test_pause_resume();
    stop = 1'b1; tick(); stop = 1'b0;
    run = 1'b1; tick();
    repeat (20) tick();
    n_chk++; if (seq !== 6'd5) begin n_fail++; $display("FAIL reach5 got %0d exp 5", seq); end
    tick(); tick();
    run = 1'b0;
    repeat (10) begin
      tick();
      n_chk++; if ({seq, stp} !== {6'd5, 1'b0}) begin n_fail++; $display("FAIL paused got seq=%0d step=%b exp 5 0", seq, stp); end
    end
    run = 1'b1;
    tick(); tick();
    n_chk++; if (seq !== 6'd5) begin n_fail++; $display("FAIL resume_early got %0d exp 5", seq); end
    tick();
    n_chk++; if ({seq, stp} !== {6'd6, 1'b1}) begin n_fail++; $display("FAIL resume_adv got seq=%0d step=%b exp 6 1", seq, stp); end
  endtask
  task automatic test_step();
    int pulses = 0;
    run = 1'b0; tick();
    step = 1'b1;
    repeat (5) begin tick(); pulses += int'(stp); end
    step = 1'b0;
    repeat (3) begin tick(); pulses += int'(stp); end
    step = 1'b1; tick(); pulses += int'(stp);
    step = 1'b0; tick(); pulses += int'(stp);
    n_chk++; if (pulses !== 2) begin n_fail++; $display("FAIL step_pulses got %0d exp 2", pulses); end
    n_chk++; if ({seq, valid} !== {6'd8, 1'b1}) begin n_fail++; $display("FAIL step_seq got seq=%0d valid=%b exp 8 1", seq, valid); end
  endtask
  task automatic test_step_in_run();
    run = 1'b1; step = 1'b1; tick();
    repeat (4) tick();
    n_chk++; if (seq !== 6'd9) begin n_fail++; $display("FAIL run_with_step got %0d exp 9", seq); end
    run = 1'b0;
    repeat (4) tick();
    n_chk++; if ({seq, stp} !== {6'd9, 1'b0}) begin n_fail++; $display("FAIL no_spurious_step got seq=%0d step=%b exp 9 0", seq, stp); end
    step = 1'b0; tick();
  endtask
  task automatic test_stop();
    run = 1'b1; tick();
    repeat (32) tick();
    n_chk++; if (seq !== 6'd17) begin n_fail++; $display("FAIL reach17 got %0d exp 17", seq); end
    stop = 1'b1; step = 1'b1; tick();
    n_chk++; if ({seq, valid, stp, wrap} !== 9'b0) begin n_fail++; $display("FAIL stop_idle got %h exp 0", {seq, valid, stp, wrap}); end
    stop = 1'b0; run = 1'b0; step = 1'b0; tick();
    n_chk++; if (valid !== 1'b0) begin n_fail++; $display("FAIL idle_hold valid=%b exp 0", valid); end
    step = 1'b1; tick();
    n_chk++; if ({seq, valid, stp} !== {6'd0, 2'b10}) begin n_fail++; $display("FAIL idle_step got seq=%0d valid=%b step=%b exp 0 1 0", seq, valid, stp); end
    step = 1'b0; run = 1'b1; tick();
    n_chk++; if ({seq, valid, stp} !== {6'd0, 2'b10}) begin n_fail++; $display("FAIL restart got seq=%0d valid=%b step=%b exp 0 1 0", seq, valid, stp); end
    repeat (4) tick();
    n_chk++; if ({seq, stp} !== {6'd1, 1'b1}) begin n_fail++; $display("FAIL restart_adv got seq=%0d step=%b exp 1 1", seq, stp); end
  endtask
  task automatic test_reset_midrun();
    stop = 1'b1; tick(); stop = 1'b0;
    tick();
    repeat (120) tick();
    n_chk++; if (seq !== 6'd30) begin n_fail++; $display("FAIL reach30 got %0d exp 30", seq); end
    rst = 1'b1; tick();
    n_chk++; if ({seq, valid, stp, wrap} !== 9'b0) begin n_fail++; $display("FAIL midrun_reset got %h exp 0", {seq, valid, stp, wrap}); end
    tick();
    rst = 1'b0; tick();
    n_chk++; if ({seq, valid, stp} !== {6'd0, 2'b10}) begin n_fail++; $display("FAIL midrun_release got seq=%0d valid=%b step=%b exp 0 1 0", seq, valid, stp); end
  endtask
  task automatic test_sweep_mode();
    logic [5:0] es;
    logic ew;
    rst1 = 1'b1; tick();
    rst1 = 1'b0; run1 = 1'b1; tick();
    n_chk++; if ({seq1, valid1, stp1} !== {6'd0, 2'b10}) begin n_fail++; $display("FAIL d1_start got seq=%0d valid=%b step=%b", seq1, valid1, stp1); end
    for (int i = 1; i <= 95; i++) begin
`ifdef GPIO_SEQ_PINGPONG_EN
      es = i <= 47 ? 6'(i) : i <= 94 ? 6'(94 - i) : 6'd1;
      ew = i == 95;
`else
      es = 6'(i % 48);
      ew = i == 48;
`endif
      tick();
      n_chk++; if ({seq1, stp1, wrap1} !== {es, 1'b1, ew}) begin n_fail++; $display("FAIL d1_sweep i=%0d got seq=%0d step=%b wrap=%b exp %0d 1 %b", i, seq1, stp1, wrap1, es, ew); end
    end
  endtask
  initial begin
    test_reset();
    test_run_sweep();
    test_pause_resume();
    test_step();
    test_step_in_run();
    test_stop();
    test_reset_midrun();
    test_sweep_mode();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
